// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared constants and receive-FSM state encoding for uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int c_min_clks_per_bit = 8;
    localparam int c_data_bits        = 8;
    localparam int c_idx_w            = $clog2(c_data_bits);

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_start   = 3'd1;
    localparam state_t c_st_data    = 3'd2;
    localparam state_t c_st_stop    = 3'd3;
    localparam state_t c_st_recover = 3'd4;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Show-ahead FIFO; a push into a full FIFO only lands when a pop
//               happens in the same cycle, otherwise it is dropped and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overflow_o
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               r_overflow;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_pop   = !w_empty && pop_ready_i;
    assign w_wr    = push_i && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
            end
            r_overflow <= push_i && w_full && !w_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= push_data_i;
        end
    end

    assign valid_o    = !w_empty;
    assign data_o     = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];
    assign overflow_o = r_overflow;

endmodule : uart_rx_fifo
`default_nettype wire

// File: rtl/uart_rx_capture.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_capture
// Description : 8N1 UART receiver with mid-bit sampling, framing-error recovery
//               and a show-ahead byte FIFO towards a valid/ready consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_capture
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_data_bits - 1);

    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic                   r_rx_prev;

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_idx_w-1:0]     r_bit_idx;
    logic [c_data_bits-1:0] r_shift;
    logic                   r_push;
    logic                   r_frame_err;

    state_t                 w_state_nxt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic [c_idx_w-1:0]     w_idx_nxt;
    logic [c_data_bits-1:0] w_shift_nxt;
    logic                   w_push_nxt;
    logic                   w_ferr_nxt;
    logic                   w_cnt_zero;

    // Synchroniser and edge-detect history idle high, matching the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_push      <= w_push_nxt;
            r_frame_err <= w_ferr_nxt;
        end
    end

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (r_rx_prev && !r_rx_s) begin
                    w_cnt_nxt   = c_half;
                    w_state_nxt = c_st_start;
                end
            end
            c_st_start: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end else if (!r_rx_s) begin
                    w_cnt_nxt   = c_full;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_st_data;
                end else begin
                    // Line was high again at mid start bit: a glitch, not a frame.
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_data: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end else begin
                    w_shift_nxt[r_bit_idx] = r_rx_s;
                    w_cnt_nxt              = c_full;
                    if (r_bit_idx == c_last) begin
                        w_state_nxt = c_st_stop;
                    end else begin
                        w_idx_nxt = r_bit_idx + c_idx_w'(1);
                    end
                end
            end
            c_st_stop: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end else if (r_rx_s) begin
                    w_push_nxt  = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = c_st_recover;
                end
            end
            c_st_recover: begin
                // Hold off until the line returns high so a break is not re-read.
                if (r_rx_s) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    uart_rx_fifo #(
        .WIDTH (c_data_bits),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (r_push),
        .push_data_i (r_shift),
        .pop_ready_i (ready_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .overflow_o  (overflow_o)
    );

    assign frame_err_o = r_frame_err;
    assign busy_o      = (r_state != c_st_idle);

endmodule : uart_rx_capture
`default_nettype wire

// File: tb/tb_uart_rx_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_capture
// Description : Scoreboard bench for uart_rx_capture with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_capture;

    localparam int CLKS_PER_BIT = 16;
    localparam int FIFO_DEPTH   = 4;

    logic       clk;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overflow_o;
    logic       busy_o;

    int         total;
    int         bad;
    int         fe_cnt;
    int         ovf_cnt;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_rx_capture #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every accepted beat is checked against the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err_o) fe_cnt++;
            if (overflow_o)  ovf_cnt++;
            if (valid_o && ready_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got %02h expected none", data_o);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (data_o !== exp_b) begin
                        bad++;
                        $display("FAIL data: got %02h expected %02h", data_o, exp_b);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_i = 1'b0;
        tick(CLKS_PER_BIT);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            tick(CLKS_PER_BIT);
        end
        rx_i = stop;
        tick(CLKS_PER_BIT);
        rx_i = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        fe_cnt  = 0;
        ovf_cnt = 0;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        rst_n   = 1'b0;
        tick(5);
        check("reset_valid", valid_o, 0);
        check("reset_data", data_o, 8'h00);
        check("reset_busy", busy_o, 0);
        check("reset_ferr", frame_err_o, 0);
        rst_n = 1'b1;
        tick(5);

        // Single clean byte.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(2 * CLKS_PER_BIT);
        wait_drain("a5_drain");
        check("a5_ferr", fe_cnt, 0);
        check("a5_ovf", ovf_cnt, 0);

        // Quarter-bit glitch on an idle line.
        rx_i = 1'b0;
        tick(CLKS_PER_BIT / 4);
        check("glitch_busy_start", busy_o, 1);
        rx_i = 1'b1;
        tick(3 * CLKS_PER_BIT);
        check("glitch_idle", busy_o, 0);
        check("glitch_valid", valid_o, 0);
        check("glitch_ferr", fe_cnt, 0);

        // Bad stop bit followed by a break, then a good byte.
        send_frame(8'h3C, 1'b0);
        rx_i = 1'b0;
        tick(3 * CLKS_PER_BIT);
        check("break_busy", busy_o, 1);
        rx_i = 1'b1;
        tick(2 * CLKS_PER_BIT);
        check("break_idle", busy_o, 0);
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1);
        tick(2 * CLKS_PER_BIT);
        wait_drain("ferr_drain");
        check("ferr_count", fe_cnt, 1);

        // Overflow with a stalled consumer.
        ready_i = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
            tick(CLKS_PER_BIT);
        end
        tick(CLKS_PER_BIT);
        check("ovf_count", ovf_cnt, 1);
        check("ovf_hold_valid", valid_o, 1);
        check("ovf_hold_data", data_o, 8'h01);
        tick(5);
        check("ovf_hold_data_later", data_o, 8'h01);
        ready_i = 1'b1;
        wait_drain("ovf_drain");

        // Full FIFO, consumer wakes up on exactly the next push cycle.
        ready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back(8'h11 + 8'(b));
            send_frame(8'h11 + 8'(b), 1'b1);
            tick(CLKS_PER_BIT);
        end
        exp_q.push_back(8'h15);
        fork
            send_frame(8'h15, 1'b1);
            begin : push_watch
                logic seen;
                seen = 1'b0;
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk);
                    #2;
                    if (dut.r_push) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("push_seen", seen, 1);
                ready_i = 1'b1;
            end
        join
        tick(CLKS_PER_BIT);
        wait_drain("simul_drain");
        check("simul_ovf", ovf_cnt, 1);

        // Reset in the middle of data bit 4 with a byte already buffered.
        ready_i = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(2 * CLKS_PER_BIT);
        rx_i = 1'b0;
        tick(CLKS_PER_BIT);
        for (int i = 0; i < 4; i++) begin
            rx_i = i[0];
            tick(CLKS_PER_BIT);
        end
        rx_i = 1'b1;
        tick(CLKS_PER_BIT / 2);
        check("pre_rst_busy", busy_o, 1);
        check("pre_rst_valid", valid_o, 1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_data", data_o, 8'h00);
        check("rst_flags", {frame_err_o, overflow_o}, 2'b00);
        exp_q.delete();
        tick(3);
        rst_n = 1'b1;
        tick(2 * CLKS_PER_BIT);
        ready_i = 1'b1;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        tick(2 * CLKS_PER_BIT);
        wait_drain("post_rst_drain");
        check("final_ferr", fe_cnt, 1);
        check("final_ovf", ovf_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx_capture
`default_nettype wire
